// File: rtl/rv_pkg.sv
// Shared integer-pipeline constants: data width, register file geometry and
// the fixed writeback producer indices.
package rv_pkg;
    localparam int XLEN        = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int NUM_REGS    = 32;
    localparam int WB_SRC_ALU  = 0;
    localparam int WB_SRC_LSU  = 1;
    localparam int WB_SRC_MDU  = 2;
endpackage

// File: rtl/regfile_wb_sched_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last_grant+1, pointer
// advances only when a granted request is acknowledged.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] ack,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_grant_reg;
    logic [PW-1:0] last_grant_next;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(last_grant_reg) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        last_grant_next = last_grant_reg;
        for (int i = 0; i < N; i++) begin
            if (ack[i]) last_grant_next = PW'(i);
        end
    end

    // Reset points at the last source so source 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_reg <= PW'(N - 1);
        else        last_grant_reg <= last_grant_next;
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates producers onto the register file write port
// and keeps per-register busy bits that raise the decode hazard stall.
module regfile_wb_sched
    import rv_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = rv_pkg::XLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rs1,
    input  logic [4:0]              issue_rs2,
    input  logic                    issue_use_rs1,
    input  logic                    issue_use_rs2,
    input  logic                    issue_has_rd,
    input  logic [4:0]              issue_rd,
    output logic                    hazard_stall,
    output logic                    issue_fire,
    input  logic [NUM_SRC-1:0]      wb_valid,
    input  logic [NUM_SRC*5-1:0]    wb_rd,
    input  logic [NUM_SRC*XLEN-1:0] wb_data,
    output logic [NUM_SRC-1:0]      wb_ready,
    output logic                    rf_write_en,
    output logic [4:0]              rf_rd,
    output logic [XLEN-1:0]         rf_write_data,
    output logic [31:0]             busy_vec
);
    logic [NUM_REGS-1:0]   busy_reg;
    logic [NUM_REGS-1:0]   busy_next;
    logic [NUM_SRC-1:0]    wb_ack;
    logic                  wb_hs;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  rf_write_en_reg;
    logic [REG_ADDR_W-1:0] rf_rd_reg;
    logic [XLEN-1:0]       rf_write_data_reg;

    assign hazard_stall = issue_valid &&
                          ((issue_use_rs1 && busy_reg[issue_rs1]) ||
                           (issue_use_rs2 && busy_reg[issue_rs2]) ||
                           (issue_has_rd  && busy_reg[issue_rd]));
    assign issue_fire   = issue_valid && !hazard_stall;

    assign wb_ack = wb_valid & wb_ready;
    assign wb_hs  = |wb_ack;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wb_valid),
        .ack   (wb_ack),
        .gnt   (wb_ready)
    );

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wb_ready[i]) begin
                sel_rd   = wb_rd[i*5 +: 5];
                sel_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes release the producer but are never presented to the file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_en_reg   <= 1'b0;
            rf_rd_reg         <= '0;
            rf_write_data_reg <= '0;
        end else if (wb_hs) begin
            rf_write_en_reg   <= (sel_rd != '0);
            rf_rd_reg         <= sel_rd;
            rf_write_data_reg <= sel_data;
        end else begin
            rf_write_en_reg   <= 1'b0;
        end
    end

    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit = issue_fire && issue_has_rd && (issue_rd == REG_ADDR_W'(gi));
            assign clr_hit = rf_write_en_reg && (rf_rd_reg == REG_ADDR_W'(gi));
            // A same-cycle set belongs to a newer producer, so it beats the clear.
            assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_reg <= '0;
        else        busy_reg <= busy_next;
    end

    assign rf_write_en   = rf_write_en_reg;
    assign rf_rd         = rf_rd_reg;
    assign rf_write_data = rf_write_data_reg;
    assign busy_vec      = busy_reg;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomised and directed bench for regfile_wb_sched against a cycle-level
// behavioural model of the scoreboard, arbiter and output register.
module tb_regfile_wb_sched;
    localparam int N  = 3;
    localparam int XW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid, issue_use_rs1, issue_use_rs2, issue_has_rd;
    logic [4:0]    issue_rs1, issue_rs2, issue_rd;
    logic          hazard_stall, issue_fire;
    logic [N-1:0]  wb_valid;
    logic [N*5-1:0]  wb_rd;
    logic [N*XW-1:0] wb_data;
    logic [N-1:0]  wb_ready;
    logic          rf_write_en;
    logic [4:0]    rf_rd;
    logic [XW-1:0] rf_write_data;
    logic [31:0]   busy_vec;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_busy [32];
    int          m_lg;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    regfile_wb_sched #(.NUM_SRC(N), .XLEN(XW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_has_rd  (issue_has_rd),
        .issue_rd      (issue_rd),
        .hazard_stall  (hazard_stall),
        .issue_fire    (issue_fire),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_ready      (wb_ready),
        .rf_write_en   (rf_write_en),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .busy_vec      (busy_vec)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_lg   = N - 1;
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    function automatic int exp_grant();
        for (int k = 1; k <= N; k++) begin
            if (wb_valid[(m_lg + k) % N]) return (m_lg + k) % N;
        end
        return -1;
    endfunction

    function automatic bit exp_stall();
        return issue_valid && ((issue_use_rs1 && m_busy[issue_rs1]) ||
                               (issue_use_rs2 && m_busy[issue_rs2]) ||
                               (issue_has_rd  && m_busy[issue_rd]));
    endfunction

    // Check one cycle against the model, then advance it across the edge.
    task automatic step(input bit release_hs);
        int          g;
        bit          st;
        logic [N-1:0] er;
        logic [31:0] ebusy;
        #1;
        g  = exp_grant();
        st = exp_stall();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        for (int r = 0; r < 32; r++) ebusy[r] = m_busy[r];
        chk("stall", 32'(hazard_stall), 32'(st));
        chk("fire",  32'(issue_fire),   32'(issue_valid && !st));
        chk("ready", 32'(wb_ready),     32'(er));
        chk("we",    32'(rf_write_en),  32'(m_we));
        chk("rf_rd", 32'(rf_rd),        32'(m_rd));
        chk("rf_data", rf_write_data,   m_data);
        chk("busy",  busy_vec,          ebusy);
        @(posedge clk);
        if (m_we && m_rd != 0) m_busy[m_rd] = 1'b0;
        if (issue_valid && !st && issue_has_rd && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        if (g >= 0) begin
            m_rd   = wb_rd[g*5 +: 5];
            m_data = wb_data[g*XW +: XW];
            m_we   = (m_rd != 0);
            m_lg   = g;
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
        if (release_hs && g >= 0) wb_valid[g] = 1'b0;
    endtask

    task automatic rand_inputs();
        issue_valid   = 1'($urandom_range(0, 1));
        issue_use_rs1 = 1'($urandom_range(0, 1));
        issue_use_rs2 = 1'($urandom_range(0, 1));
        issue_has_rd  = 1'($urandom_range(0, 1));
        issue_rs1     = 5'($urandom_range(0, 7));
        issue_rs2     = 5'($urandom_range(0, 7));
        issue_rd      = 5'($urandom_range(0, 7));
        for (int i = 0; i < N; i++) begin
            if (!wb_valid[i] && $urandom_range(0, 1) == 1) begin
                wb_valid[i]        = 1'b1;
                wb_rd[i*5 +: 5]    = 5'($urandom_range(0, 7));
                wb_data[i*XW +: XW] = $urandom;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] rr_tab [3];
        rr_tab[0] = 3'b001; rr_tab[1] = 3'b010; rr_tab[2] = 3'b100;
        rst_n = 1'b0;
        {issue_valid, issue_use_rs1, issue_use_rs2, issue_has_rd} = '0;
        {issue_rs1, issue_rs2, issue_rd} = '0;
        wb_valid = '0; wb_rd = '0; wb_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_busy", busy_vec, 32'h0);
        chk("reset_we", 32'(rf_write_en), 32'h0);
        step(1'b0);

        // All producers continuously valid: grants rotate 0,1,2,0...
        wb_valid = 3'b111;
        wb_rd    = {5'd3, 5'd2, 5'd1};
        wb_data  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_seq", 32'(wb_ready), 32'(rr_tab[c % 3]));
            if (c > 0) chk("rr_we", 32'(rf_write_en), 32'h1);
            step(1'b0);
        end
        wb_valid = '0;
        step(1'b0);

        // RAW on x5 released two cycles after the ALU handshake.
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd5;
        #1; chk("x5_fire", 32'(issue_fire), 32'h1);
        step(1'b0);
        issue_has_rd = 1'b0; issue_use_rs1 = 1'b1; issue_rs1 = 5'd5;
        #1; chk("raw_stall", 32'(hazard_stall), 32'h1);
        step(1'b0);
        wb_valid = 3'b001; wb_rd[4:0] = 5'd5; wb_data[31:0] = 32'hDEADBEEF;
        #1; chk("raw_stall_n", 32'(hazard_stall), 32'h1);
        step(1'b1);
        #1;
        chk("wb_we", 32'(rf_write_en), 32'h1);
        chk("wb_rd", 32'(rf_rd), 32'd5);
        chk("wb_data", rf_write_data, 32'hDEADBEEF);
        chk("raw_stall_n1", 32'(hazard_stall), 32'h1);
        step(1'b0);
        #1; chk("raw_stall_n2", 32'(hazard_stall), 32'h0);
        step(1'b0);
        issue_valid = 1'b0; issue_use_rs1 = 1'b0;

        // Issue x7 while x7 is being written: set wins.
        wb_valid = 3'b010; wb_rd[9:5] = 5'd7;
        step(1'b1);
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd7;
        #1; chk("x7_fire", 32'(issue_fire), 32'h1);
        step(1'b0);
        issue_valid = 1'b0;
        #1; chk("x7_busy", 32'(busy_vec[7]), 32'h1);

        // x0 writeback is accepted but never reaches the file.
        wb_valid = 3'b010; wb_rd[9:5] = 5'd0;
        #1; chk("x0_ready", 32'(wb_ready), 32'b010);
        step(1'b1);
        #1;
        chk("x0_we", 32'(rf_write_en), 32'h0);
        chk("x0_busy", 32'(busy_vec[0]), 32'h0);
        step(1'b0);

        // WAW on x9.
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd9;
        step(1'b0);
        #1;
        chk("waw_stall", 32'(hazard_stall), 32'h1);
        chk("waw_fire", 32'(issue_fire), 32'h0);
        step(1'b0);

        // Reset mid-stream with busy bits and a pending write.
        issue_rd = 5'd12;
        wb_valid = 3'b001; wb_rd[4:0] = 5'd4; wb_data[31:0] = 32'h0000_1234;
        step(1'b1);
        issue_valid = 1'b0;
        #1; chk("pre_rst_we", 32'(rf_write_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_we", 32'(rf_write_en), 32'h0);
        model_reset();
        wb_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        wb_valid = 3'b111; wb_rd = {5'd3, 5'd2, 5'd1};
        #1; chk("rst_first", 32'(wb_ready), 32'b001);
        step(1'b1);
        wb_valid = '0;
        step(1'b0);

        repeat (400) begin
            rand_inputs();
            step(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler and scoreboard for the 32×32 integer register file: up to three writeback producers (ALU, LSU, MDU) share the file's single write port through a round-robin valid/ready arbiter. Per-register busy bits track issued-but-not-written destinations and drive a decode-stage hazard stall. The block sits between the execute-side producers and the register file's `write_en`/`rd`/`write_data` port. It also sits beside decode, which consumes `hazard_stall`.

## Interface
- `NUM_SRC`, 3, number of writeback producers (2..4); index 0 = ALU, 1 = LSU, 2 = MDU
- `XLEN`, 32, data width
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `issue_valid` in 1: decode presents an instruction
- `issue_rs1`, `issue_rs2` in 5 each: source register indices
- `issue_use_rs1`, `issue_use_rs2` in 1 each: source actually read
- `issue_has_rd` in 1: instruction writes `issue_rd`
- `issue_rd` in 5: destination index
- `hazard_stall` out 1: combinational; decode must hold
- `issue_fire` out 1: `issue_valid && !hazard_stall`
- `wb_valid` in NUM_SRC: producer has a result
- `wb_rd` in NUM_SRC*5: packed destinations, source i at [i*5 +: 5]
- `wb_data` in NUM_SRC*XLEN: packed results
- `wb_ready` out NUM_SRC: one-hot grant, combinational
- `rf_write_en`, `rf_rd`, `rf_write_data` out 1/5/XLEN: registered, to the register file write port
- `busy_vec` out 32: scoreboard state (debug/verification)

## Operation
- Scoreboard: 32 busy bits. Bit 0 is hardwired 0.
  - On `issue_fire && issue_has_rd && issue_rd != 0`, set `busy[issue_rd]`.
  - On a registered write with `rf_write_en && rf_rd != 0`, clear `busy[rf_rd]` at that same edge.
  - Set and clear of the same index in one cycle: the set wins, because it belongs to a newer producer.
- `hazard_stall` = `issue_valid` && any of:
  - (`issue_use_rs1` && `busy[issue_rs1]`)
  - (`issue_use_rs2` && `busy[issue_rs2]`)
  - (`issue_has_rd` && `busy[issue_rd]`), the WAW case
- Arbiter: round-robin over `wb_valid`.
  - Search starts at `last_grant+1` mod NUM_SRC.
  - At most one `wb_ready` bit is high, and only for a valid source.
  - Handshake = `wb_valid[i] && wb_ready[i]`. Producers hold `wb_valid`, `wb_rd` and `wb_data` stable until the handshake.
  - `last_grant` updates only on a handshake.
- Output register: on a handshake, capture `rf_rd`/`rf_write_data` from the granted source and set `rf_write_en = (wb_rd != 0)`. With no handshake, `rf_write_en` = 0.
  - A write to x0 is still accepted (the producer is released) but never reaches the file.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - all busy bits = 0
  - `last_grant` = NUM_SRC-1, so source 0 has first priority
  - `rf_write_en` = 0, `rf_rd` = 0, `rf_write_data` = 0
- Reset mid-operation drops any pending write and all busy state. Producers are reset by the same `rst_n`.

## Timing
- Cycle N: handshake. Cycle N+1: `rf_write_en` high, and the file writes at the end of N+1. `busy` clears at that same edge.
- A reader of that register stalls through N+1 and issues in N+2. There is no bypass in this block.
- Arbitration is one grant per cycle, giving sustained throughput of 1 write/cycle.
- Starvation bound: a continuously valid source is granted within NUM_SRC cycles.
- `hazard_stall`, `issue_fire` and `wb_ready` are combinational from inputs and state. There are no combinational paths from `rf_*`.

## Structure
- Shared package `rv_pkg`:
  - `XLEN`
  - `REG_ADDR_W` = 5
  - `NUM_REGS` = 32
  - source index constants `WB_SRC_ALU`=0, `WB_SRC_LSU`=1, `WB_SRC_MDU`=2
- One natural sub-module: `rr_arbiter` (parameterised `N`). It has inputs `req`, `ack`, outputs one-hot `gnt`, and owns the `last_grant` pointer.
- The scoreboard and the output register stay in the top.

## Test plan
- Reset, then all three `wb_valid` high continuously with rd = 1, 2, 3 → grants 0, 1, 2, 0… on successive cycles, with `rf_write_en` high every cycle from the second cycle on.
- Issue rd = 5 and have it fire; next cycle issue with rs1 = 5 → `hazard_stall` = 1. ALU handshakes rd = 5, data 0xDEADBEEF in cycle N → `rf_write_en` with rd 5 and 0xDEADBEEF in N+1, and the stall drops in N+2.
- Issue rd = 7 in the same cycle that `rf_rd` = 7 is being written → `busy[7]` remains 1 after the edge.
- `wb_rd` = 0 from LSU with `wb_valid` → `wb_ready[1]` = 1, `rf_write_en` = 0 in the next cycle, and `busy_vec[0]` = 0 always.
- Issue with `issue_has_rd`, rd = 9 while `busy[9]` = 1 → `hazard_stall` = 1 and `issue_fire` = 0.
- Assert `rst_n` = 0 mid-stream with busy bits set and `rf_write_en` = 1 → immediately `busy_vec` = 0 and `rf_write_en` = 0. After release, source 0 is granted first.
